tm1638_responder: RTL and testbench

//  Synthesizable TM1638 device model: the responder end of the STB/CLK/DIO link that the
//  tm1638 controller drives. Oversamples the serial bus with CLK_IN, decodes data/address/

---
 rtl/tm1638_responder.sv | 172 +++++++++++++++++
 tb/tb_tm1638_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_responder.sv
// TM1638 device model: decodes STB/CLK/DIO commands, holds 16x8 display RAM, returns key-scan bits.
// Optional write-strobe outputs (WR_VALID/WR_ADDR/WR_DATA) enabled by TM1638_RESP_WR_STROBE_EN.
module tm1638_responder #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        CLK_IN,
   input  logic        RST_IN,
   input  logic        TM1638_STB,
   input  logic        TM1638_CLK,
   inout  wire         TM1638_DIO,
   input  logic [31:0] KEYS,
   input  logic [3:0]  RAM_RADDR,
   output logic [7:0]  RAM_RDATA,
   output logic        DISP_ON,
   output logic [2:0]  BRIGHTNESS,
   output logic        CMD_ERR,
   output logic        FRAME_DONE
`ifdef TM1638_RESP_WR_STROBE_EN
   ,
   output logic        WR_VALID,
   output logic [3:0]  WR_ADDR,
   output logic [7:0]  WR_DATA
`endif
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CMD    = 3'd1;
   localparam logic [2:0] ST_WRITE  = 3'd2;
   localparam logic [2:0] ST_READ   = 3'd3;
   localparam logic [2:0] ST_IGNORE = 3'd4;

   logic [SYNC_STAGES-1:0] stb_sync, clk_sync, dio_sync;
   logic                   stb_prev, clk_prev;
   logic                   stb_s, clk_s, dio_s;
   logic                   stb_rise, stb_fall, clk_rise, clk_fall;

   logic [2:0]  state;
   logic [2:0]  bit_cnt;
   logic [7:0]  shift_in;
   logic [7:0]  byte_next;
   logic        byte_done;
   logic        fixed_addr;
   logic [3:0]  addr;
   logic [31:0] key_sh;
   logic [5:0]  rd_cnt;
   logic        dio_oe;
   logic [7:0]  ram [16];

   // Synchronizers track the pins even through reset, so a strobe already low at
   // reset release cannot masquerade as a new frame start.
   always_ff @(posedge CLK_IN) begin
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], TM1638_STB};
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], TM1638_CLK};
      dio_sync <= {dio_sync[SYNC_STAGES-2:0], TM1638_DIO};
      stb_prev <= stb_sync[SYNC_STAGES-1];
      clk_prev <= clk_sync[SYNC_STAGES-1];
   end

   assign stb_s    = stb_sync[SYNC_STAGES-1];
   assign clk_s    = clk_sync[SYNC_STAGES-1];
   assign dio_s    = dio_sync[SYNC_STAGES-1];
   assign stb_fall = stb_prev & ~stb_s;
   assign stb_rise = ~stb_prev & stb_s;
   assign clk_rise = ~clk_prev & clk_s & ~stb_s;
   assign clk_fall = clk_prev & ~clk_s & ~stb_s;

   assign byte_next = {dio_s, shift_in[7:1]};
   assign byte_done = clk_rise && (bit_cnt == 3'd7);

   assign TM1638_DIO = dio_oe ? 1'b0 : 1'bz;

   always_ff @(posedge CLK_IN) begin
      if (!RST_IN) begin
         state      <= ST_IDLE;
         bit_cnt    <= 3'd0;
         shift_in   <= 8'h00;
         fixed_addr <= 1'b0;
         addr       <= 4'd0;
         key_sh     <= 32'd0;
         rd_cnt     <= 6'd0;
         dio_oe     <= 1'b0;
         DISP_ON    <= 1'b0;
         BRIGHTNESS <= 3'd0;
         CMD_ERR    <= 1'b0;
         FRAME_DONE <= 1'b0;
         RAM_RDATA  <= 8'h00;
         for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
`ifdef TM1638_RESP_WR_STROBE_EN
         WR_VALID   <= 1'b0;
         WR_ADDR    <= 4'd0;
         WR_DATA    <= 8'h00;
`endif
      end else begin
         CMD_ERR    <= 1'b0;
         FRAME_DONE <= 1'b0;
         RAM_RDATA  <= ram[RAM_RADDR];
`ifdef TM1638_RESP_WR_STROBE_EN
         WR_VALID   <= 1'b0;
`endif
         if (stb_rise) begin
            state      <= ST_IDLE;
            dio_oe     <= 1'b0;
            FRAME_DONE <= 1'b1;
         end else if (stb_fall) begin
            state   <= ST_CMD;
            bit_cnt <= 3'd0;
            dio_oe  <= 1'b0;
         end else if (state != ST_IDLE) begin
            if (clk_rise) begin
               shift_in <= byte_next;
               bit_cnt  <= bit_cnt + 3'd1;
            end
            case (state)
               ST_CMD: begin
                  if (byte_done) begin
                     case (byte_next[7:6])
                        2'b01: begin
                           fixed_addr <= byte_next[2];
                           if (byte_next[1]) begin
                              key_sh <= KEYS;
                              rd_cnt <= 6'd0;
                              state  <= ST_READ;
                           end else begin
                              state  <= ST_IGNORE;
                           end
                        end
                        2'b11: begin
                           addr  <= byte_next[3:0];
                           state <= ST_WRITE;
                        end
                        2'b10: begin
                           DISP_ON    <= byte_next[3];
                           BRIGHTNESS <= byte_next[2:0];
                           state      <= ST_IGNORE;
                        end
                        default: begin
                           CMD_ERR <= 1'b1;
                           state   <= ST_IGNORE;
                        end
                     endcase
                  end
               end
               ST_WRITE: begin
                  if (byte_done) begin
                     ram[addr] <= byte_next;
                     if (!fixed_addr) addr <= addr + 4'd1;
`ifdef TM1638_RESP_WR_STROBE_EN
                     WR_VALID <= 1'b1;
                     WR_ADDR  <= addr;
                     WR_DATA  <= byte_next;
`endif
                  end
               end
               ST_READ: begin
                  // Bit is driven on the fall, master samples it on the next rise;
                  // release only after that rise has consumed bit 31.
                  if (clk_fall && rd_cnt < 6'd32) begin
                     dio_oe <= ~key_sh[0];
                     key_sh <= {1'b0, key_sh[31:1]};
                     rd_cnt <= rd_cnt + 6'd1;
                  end else if (clk_rise && rd_cnt == 6'd32) begin
                     dio_oe <= 1'b0;
                     state  <= ST_IGNORE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder: bit-banged master frames with hand-computed expectations.
module tb_tm1638_responder;

   localparam int HALF = 80;

   logic        CLK_IN = 1'b0;
   logic        RST_IN = 1'b0;
   logic        stb = 1'b1;
   logic        mclk = 1'b1;
   logic        drv_en = 1'b0;
   logic        drv_val = 1'b1;
   logic [31:0] KEYS = 32'd0;
   logic [3:0]  RAM_RADDR = 4'd0;
   logic [7:0]  RAM_RDATA;
   logic        DISP_ON;
   logic [2:0]  BRIGHTNESS;
   logic        CMD_ERR;
   logic        FRAME_DONE;
   wire         dio;
`ifdef TM1638_RESP_WR_STROBE_EN
   logic        WR_VALID;
   logic [3:0]  WR_ADDR;
   logic [7:0]  WR_DATA;
`endif

   int n_vec = 0;
   int n_err = 0;
   int fd_cnt = 0;
   int err_cnt = 0;

   assign dio = drv_en ? drv_val : 1'bz;
   pullup (dio);

   always #5 CLK_IN = ~CLK_IN;

   always @(posedge CLK_IN) begin
      if (FRAME_DONE) fd_cnt <= fd_cnt + 1;
      if (CMD_ERR) err_cnt <= err_cnt + 1;
   end

   tm1638_responder #(.SYNC_STAGES(2)) dut (
      .CLK_IN(CLK_IN),
      .RST_IN(RST_IN),
      .TM1638_STB(stb),
      .TM1638_CLK(mclk),
      .TM1638_DIO(dio),
      .KEYS(KEYS),
      .RAM_RADDR(RAM_RADDR),
      .RAM_RDATA(RAM_RDATA),
      .DISP_ON(DISP_ON),
      .BRIGHTNESS(BRIGHTNESS),
      .CMD_ERR(CMD_ERR),
      .FRAME_DONE(FRAME_DONE)
`ifdef TM1638_RESP_WR_STROBE_EN
      ,
      .WR_VALID(WR_VALID),
      .WR_ADDR(WR_ADDR),
      .WR_DATA(WR_DATA)
`endif
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      drv_en = 1'b1;
      for (int i = 0; i < n; i++) begin
         mclk = 1'b0;
         drv_val = b[i];
         #HALF;
         mclk = 1'b1;
         #HALF;
      end
   endtask

   task automatic frame_start();
      stb = 1'b0;
      #HALF;
   endtask

   task automatic frame_end();
      #HALF;
      drv_en = 1'b0;
      stb = 1'b1;
      #(4*HALF);
   endtask

   task automatic frame1(input logic [7:0] b0);
      frame_start();
      send_bits(b0, 8);
      frame_end();
   endtask

   task automatic read_byte(output logic [7:0] b);
      for (int i = 0; i < 8; i++) begin
         mclk = 1'b0;
         #HALF;
         b[i] = dio;
         mclk = 1'b1;
         #HALF;
      end
   endtask

   task automatic read_ram(input logic [3:0] a, output logic [7:0] v);
      @(negedge CLK_IN);
      RAM_RADDR = a;
      @(negedge CLK_IN);
      @(negedge CLK_IN);
      v = RAM_RDATA;
   endtask

   logic [7:0] v;
   int fd0;
   int er0;

   initial begin
      repeat (4) @(negedge CLK_IN);
      check("rst_rdata", {24'd0, RAM_RDATA}, 32'h00);
      check("rst_disp_on", {31'd0, DISP_ON}, 32'd0);
      check("rst_bright", {29'd0, BRIGHTNESS}, 32'd0);
      check("rst_cmd_err", {31'd0, CMD_ERR}, 32'd0);
      check("rst_frame_done", {31'd0, FRAME_DONE}, 32'd0);
      check("rst_dio_released", {31'd0, dio}, 32'd1);
      RST_IN = 1'b1;
      repeat (4) @(negedge CLK_IN);

      // Auto-increment write from address 0
      fd0 = fd_cnt;
      frame1(8'h40);
      frame_start();
      send_bits(8'hC0, 8); send_bits(8'h3F, 8); send_bits(8'h06, 8); send_bits(8'h5B, 8);
      frame_end();
      check("frame_done_cnt", fd_cnt - fd0, 2);
      read_ram(4'd0, v);  check("ram0", {24'd0, v}, 32'h3F);
      read_ram(4'd1, v);  check("ram1", {24'd0, v}, 32'h06);
      read_ram(4'd2, v);  check("ram2", {24'd0, v}, 32'h5B);
      read_ram(4'd3, v);  check("ram3", {24'd0, v}, 32'h00);
      read_ram(4'd15, v); check("ram15_init", {24'd0, v}, 32'h00);

      // Fixed address: second byte overwrites ram[5]
      frame1(8'h44);
      frame_start();
      send_bits(8'hC5, 8); send_bits(8'h11, 8); send_bits(8'h22, 8);
      frame_end();
      read_ram(4'd5, v); check("fixed_ram5", {24'd0, v}, 32'h22);
      read_ram(4'd6, v); check("fixed_ram6", {24'd0, v}, 32'h00);

      // Address wrap 15 -> 0
      frame1(8'h40);
      frame_start();
      send_bits(8'hCF, 8); send_bits(8'hAA, 8); send_bits(8'hBB, 8);
      frame_end();
      read_ram(4'd15, v); check("wrap_ram15", {24'd0, v}, 32'hAA);
      read_ram(4'd0, v);  check("wrap_ram0", {24'd0, v}, 32'hBB);

      // Key read
      KEYS = 32'h8001_4002;
      frame_start();
      send_bits(8'h42, 8);
      drv_en = 1'b0;
      read_byte(v); check("key_byte0", {24'd0, v}, 32'h02);
      read_byte(v); check("key_byte1", {24'd0, v}, 32'h40);
      read_byte(v); check("key_byte2", {24'd0, v}, 32'h01);
      read_byte(v); check("key_byte3", {24'd0, v}, 32'h80);
      for (int i = 0; i < 2; i++) begin
         mclk = 1'b0; #HALF;
         check("dio_after_read", {31'd0, dio}, 32'd1);
         mclk = 1'b1; #HALF;
      end
      frame_end();

      // Display control and illegal command
      frame1(8'h8C);
      check("disp_on", {31'd0, DISP_ON}, 32'd1);
      check("brightness", {29'd0, BRIGHTNESS}, 32'd4);
      er0 = err_cnt;
      frame1(8'h05);
      check("cmd_err_pulse", err_cnt - er0, 1);
      check("disp_on_kept", {31'd0, DISP_ON}, 32'd1);
      check("brightness_kept", {29'd0, BRIGHTNESS}, 32'd4);

      // Aborted byte must not reach RAM
      frame_start();
      send_bits(8'hC2, 8);
      send_bits(8'hFF, 5);
      frame_end();
      read_ram(4'd2, v); check("abort_ram2", {24'd0, v}, 32'h5B);

      // Reset in the middle of a read
      KEYS = 32'h0000_0000;
      frame_start();
      send_bits(8'h42, 8);
      drv_en = 1'b0;
      mclk = 1'b0;
      #HALF;
      check("rd_drive_low", {31'd0, dio}, 32'd0);
      @(negedge CLK_IN);
      RST_IN = 1'b0;
      repeat (3) @(negedge CLK_IN);
      check("rst_mid_dio", {31'd0, dio}, 32'd1);
      check("rst_mid_disp", {31'd0, DISP_ON}, 32'd0);
      RST_IN = 1'b1;
      mclk = 1'b1;
      stb = 1'b1;
      #(4*HALF);
      read_ram(4'd2, v); check("rst_mid_ram2", {24'd0, v}, 32'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
